mlp_layer_reader: RTL and testbench

- Controls one layer of PE neurons and reads their results back.
- Holds the PE array in reset while idle. Releases it for one pass, driving the pixel address that the PEs' `bus_in` mux sequence expects.
- Captures all PE `acc_out` values once accumulation (bias included) is complete.
- Scans the captured values serially and reports the argmax class and its value.

---
 rtl/mlp_layer_reader_if.sv | 62 ++++++
 rtl/mlp_layer_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_mlp_layer_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_layer_reader_if
//  Description : Bundle of control, PE-side and result signals for the
//                MLP layer reader. The reader itself connects through the
//                slave modport; the environment (PE array wrapper, pixel
//                memory, host) connects through the master modport.
//
//  Signals
//    start      host -> reader  one-cycle request to run a layer pass
//    acc_in     PEs  -> reader  packed accumulators, element i at [i*TAM +: TAM]
//    pe_rst     reader -> PEs   active-high PE reset
//    pix_addr   reader -> mem   input element index placed on PE bus_in
//    busy       reader -> host  high whenever the reader is not idle
//    out_valid  reader -> host  one-cycle result strobe
//    class_idx  reader -> host  argmax index
//    max_val    reader -> host  argmax value
//
//  Revision    : 1.0  initial release
// ============================================================================
interface mlp_layer_reader_if #(
    parameter int TAM       = 16,
    parameter int DATA_SIZE = 784,
    parameter int N_OUT     = 10
) ();

    localparam int c_ADDR_W = $clog2(DATA_SIZE + 1);
    localparam int c_IDX_W  = $clog2(N_OUT);

    logic                   start;
    logic [N_OUT*TAM-1:0]   acc_in;
    logic                   pe_rst;
    logic [c_ADDR_W-1:0]    pix_addr;
    logic                   busy;
    logic                   out_valid;
    logic [c_IDX_W-1:0]     class_idx;
    logic [TAM-1:0]         max_val;

    modport master (
        output start,
        output acc_in,
        input  pe_rst,
        input  pix_addr,
        input  busy,
        input  out_valid,
        input  class_idx,
        input  max_val
    );

    modport slave (
        input  start,
        input  acc_in,
        output pe_rst,
        output pix_addr,
        output busy,
        output out_valid,
        output class_idx,
        output max_val
    );

endinterface
`default_nettype wire

// File: rtl/mlp_layer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_layer_reader
//  Description : Drives one layer of PE neurons through a single
//                accumulation pass and reads back the argmax.
//
//                IDLE    : PEs held in reset, waiting for start.
//                CLEAR   : one cycle, address counter cleared, PEs still reset.
//                RUN     : DATA_SIZE+1 cycles, counter walks 0..DATA_SIZE in
//                          lock-step with the PE select (last step = bias).
//                CAPTURE : all PE accumulators latched into a local array.
//                SCAN    : one element per cycle, signed strict-greater max.
//                DONE    : one-cycle out_valid, result registers updated.
//
//  Ports
//    clk   in   clock
//    rst   in   asynchronous active-low reset
//    bus   slave modport of mlp_layer_reader_if
//            start(in) acc_in(in) pe_rst(out) pix_addr(out) busy(out)
//            out_valid(out) class_idx(out) max_val(out)
//
//  Revision    : 1.0  initial release
// ============================================================================
module mlp_layer_reader #(
    parameter int TAM       = 16,
    parameter int DATA_SIZE = 784,
    parameter int N_OUT     = 10
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mlp_layer_reader_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(DATA_SIZE + 1);
    localparam int c_IDX_W = $clog2(N_OUT);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_SIZE);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_OUT - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_SCAN    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [TAM-1:0]         r_elem [N_OUT];
    logic [TAM-1:0]         r_best;
    logic [c_IDX_W-1:0]     r_best_idx;

    logic                   r_pe_rst;
    logic                   r_busy;
    logic                   r_out_valid;
    logic [c_IDX_W-1:0]     r_class_idx;
    logic [TAM-1:0]         r_max_val;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [TAM-1:0]         w_acc [N_OUT];
    logic [TAM-1:0]         w_cand;
    logic                   w_take;
    logic [TAM-1:0]         w_best_nxt;
    logic [c_IDX_W-1:0]     w_best_idx_nxt;

    // Split the packed PE bus into one word per neuron.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_unpack
            assign w_acc[gi] = bus.acc_in[gi*TAM +: TAM];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // The cycle with cnt == DATA_SIZE is the bias step; the PEs
                // have finished accumulating once it has been clocked in.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Argmax step. Element 0 always seeds the running best; later elements
    // replace it only when strictly greater, so ties keep the lower index.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cand         = r_elem[r_idx];
        w_take         = (r_idx == '0) || ($signed(w_cand) > $signed(r_best));
        w_best_nxt     = r_best;
        w_best_idx_nxt = r_best_idx;
        if (w_take) begin
            w_best_nxt     = w_cand;
            w_best_idx_nxt = r_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_pe_rst    <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_class_idx <= '0;
            r_max_val   <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            // Output flags follow the state being entered so that they are
            // registered yet aligned with the state they describe.
            r_pe_rst    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);

            unique case (r_state)
                S_CLEAR: begin
                    r_cnt <= '0;
                end
                S_RUN: begin
                    // Saturates at DATA_SIZE; holds there until the next CLEAR.
                    if (r_cnt != c_CNT_LAST) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < N_OUT; i++) begin
                        r_elem[i] <= w_acc[i];
                    end
                    r_idx <= '0;
                end
                S_SCAN: begin
                    r_best     <= w_best_nxt;
                    r_best_idx <= w_best_idx_nxt;
                    if (r_idx == c_IDX_LAST) begin
                        // Publish the final comparison directly so the result
                        // is ready in the same edge that raises out_valid.
                        r_class_idx <= w_best_idx_nxt;
                        r_max_val   <= w_best_nxt;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.pe_rst    = r_pe_rst;
    assign bus.pix_addr  = r_cnt;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.class_idx = r_class_idx;
    assign bus.max_val   = r_max_val;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mlp_layer_reader
//  Description : Directed bench for mlp_layer_reader with DATA_SIZE=4,
//                N_OUT=3, TAM=16. Argmax vectors come from a table; timing,
//                ignored starts, back-to-back passes and mid-pass reset are
//                hand-written sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mlp_layer_reader;

    localparam int TAM       = 16;
    localparam int DATA_SIZE = 4;
    localparam int N_OUT     = 3;
    localparam int LAT       = DATA_SIZE + N_OUT + 3;   // edge of out_valid

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [1:0]  cls;
        logic [15:0] val;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    vec_t vecs [7];

    mlp_layer_reader_if #(.TAM(TAM), .DATA_SIZE(DATA_SIZE), .N_OUT(N_OUT)) bus ();

    mlp_layer_reader #(.TAM(TAM), .DATA_SIZE(DATA_SIZE), .N_OUT(N_OUT)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; sample point is 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pass: start sampled at edge 0, with optional extra start pulses at
    // edges 3 and 7 that must be ignored. Checks every edge 0..LAT+4.
    task automatic run_pass(input vec_t v, input bit extra, input string tag);
        bus.acc_in = {v.e2, v.e1, v.e0};
        for (int k = 0; k <= LAT + 4; k++) begin
            bus.start = (k == 0) || (extra && (k == 3 || k == 7));
            tick();
            bus.start = 1'b0;
            check($sformatf("%s pe_rst e%0d", tag, k), 32'(bus.pe_rst),
                  (k >= 1 && k <= LAT) ? 32'd0 : 32'd1);
            check($sformatf("%s busy e%0d", tag, k), 32'(bus.busy),
                  (k <= LAT) ? 32'd1 : 32'd0);
            check($sformatf("%s out_valid e%0d", tag, k), 32'(bus.out_valid),
                  (k == LAT) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= DATA_SIZE + 1) begin
                check($sformatf("%s pix_addr e%0d", tag, k), 32'(bus.pix_addr), 32'(k - 1));
            end
            if (k >= LAT) begin
                check($sformatf("%s class_idx e%0d", tag, k), 32'(bus.class_idx), 32'(v.cls));
                check($sformatf("%s max_val e%0d", tag, k), 32'(bus.max_val), 32'(v.val));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //           e0        e1        e2       cls   max
        vecs[0] = '{16'h0020, 16'h0030, 16'h0010, 2'd1, 16'h0030};
        vecs[1] = '{16'hFFF0, 16'h0005, 16'h0005, 2'd1, 16'h0005};
        vecs[2] = '{16'hFFFE, 16'hFFFF, 16'h8000, 2'd1, 16'hFFFF};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 2'd0, 16'h7FFF};
        vecs[4] = '{16'h8000, 16'h8000, 16'h8001, 2'd2, 16'h8001};
        vecs[5] = '{16'h0001, 16'h0000, 16'hFFFF, 2'd0, 16'h0001};
        vecs[6] = '{16'h8000, 16'h7FFF, 16'h0000, 2'd1, 16'h7FFF};

        bus.start  = 1'b0;
        bus.acc_in = '0;
        rst_n      = 1'b0;
        repeat (3) tick();

        // Values held while reset is asserted.
        check("rst pe_rst", 32'(bus.pe_rst), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst pix_addr", 32'(bus.pix_addr), 32'd0);
        check("rst class_idx", 32'(bus.class_idx), 32'd0);
        check("rst max_val", 32'(bus.max_val), 32'd0);

        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("idle pe_rst c%0d", k), 32'(bus.pe_rst), 32'd1);
            check($sformatf("idle busy c%0d", k), 32'(bus.busy), 32'd0);
            check($sformatf("idle out_valid c%0d", k), 32'(bus.out_valid), 32'd0);
            check($sformatf("idle pix_addr c%0d", k), 32'(bus.pix_addr), 32'd0);
        end

        // Table of argmax vectors.
        for (int i = 0; i < 7; i++) begin
            run_pass(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Extra start pulses during a running pass are ignored.
        run_pass(vecs[0], 1'b1, "ignore");

        // Start held high: second pass accepted at edge LAT+2.
        bus.acc_in = {vecs[4].e2, vecs[4].e1, vecs[4].e0};
        bus.start  = 1'b1;
        for (int k = 0; k <= 2 * LAT + 2; k++) begin
            tick();
            check($sformatf("b2b out_valid e%0d", k), 32'(bus.out_valid),
                  (k == LAT || k == 2 * LAT + 2) ? 32'd1 : 32'd0);
            check($sformatf("b2b busy e%0d", k), 32'(bus.busy),
                  (k == LAT + 1) ? 32'd0 : 32'd1);
        end
        bus.start = 1'b0;
        repeat (2) tick();
        check("b2b idle busy", 32'(bus.busy), 32'd0);
        check("b2b class_idx", 32'(bus.class_idx), 32'(vecs[4].cls));
        check("b2b max_val", 32'(bus.max_val), 32'(vecs[4].val));

        // Reset during SCAN: result lost, no strobe.
        bus.acc_in = {vecs[0].e2, vecs[0].e1, vecs[0].e0};
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        repeat (8) tick();          // edge 8: inside SCAN
        check("mid busy before rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid busy", 32'(bus.busy), 32'd0);
        check("mid pe_rst", 32'(bus.pe_rst), 32'd1);
        check("mid class_idx", 32'(bus.class_idx), 32'd0);
        check("mid max_val", 32'(bus.max_val), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("post-rst out_valid c%0d", k), 32'(bus.out_valid), 32'd0);
            check($sformatf("post-rst busy c%0d", k), 32'(bus.busy), 32'd0);
        end
        run_pass(vecs[2], 1'b0, "after-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
